// File: rtl/echo_heard_queue.sv
// Sequence-tagging FIFO between heard and out; entries become visible one cycle after acceptance.
// heard__RDY drops only on registered full (no bypass); out holds its head entry while out__RDY is low.
module echo_heard_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     heard__ENA,
  input  logic [WIDTH-1:0]         heard_v,
  output logic                     heard__RDY,
  output logic                     out__ENA,
  output logic [WIDTH-1:0]         out_v,
  output logic [15:0]              out_seq,
  input  logic                     out__RDY,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [15:0]      seq;
    logic [WIDTH-1:0] dat;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [15:0]   seq_q;
  logic          enq;
  logic          deq;
  logic          not_empty;

  assign not_empty  = (count_q != '0);
  assign heard__RDY = (count_q != FULL);
  assign enq        = heard__ENA & heard__RDY;
  assign out__ENA   = not_empty & out__RDY;
  assign deq        = out__ENA;
  assign head       = mem[rd_ptr];
  assign out_v      = not_empty ? head.dat : '0;
  assign out_seq    = not_empty ? head.seq : '0;
  assign count      = count_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr] <= {seq_q, heard_v};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      seq_q   <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq_q  <= seq_q + 16'd1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CW'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_echo_heard_queue.sv
// Directed bench for echo_heard_queue: reset, single pass, fill/full, full+dequeue, streaming, async reset, seq wrap.
module tb_echo_heard_queue;

  logic        CLK;
  logic        nRST;
  logic        heard__ENA;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        out__ENA;
  logic [31:0] out_v;
  logic [15:0] out_seq;
  logic        out__RDY;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  echo_heard_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .heard__ENA (heard__ENA),
    .heard_v    (heard_v),
    .heard__RDY (heard__RDY),
    .out__ENA   (out__ENA),
    .out_v      (out_v),
    .out_seq    (out_seq),
    .out__RDY   (out__RDY),
    .count      (count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
    #1;
  endtask

  task automatic fill4(input logic [31:0] base, input logic [31:0] stride);
    out__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      heard__ENA = 1'b1;
      heard_v    = base + stride * 32'(i);
      tick();
    end
    heard__ENA = 1'b0;
    settle();
  endtask

  initial begin
    nRST       = 1'b0;
    heard__ENA = 1'b0;
    heard_v    = '0;
    out__RDY   = 1'b1;

    // Reset state
    #2;
    chk("rst_heard_rdy", 32'(heard__RDY), 32'd1);
    chk("rst_out_ena",   32'(out__ENA),   32'd0);
    chk("rst_out_v",     out_v,           32'd0);
    chk("rst_out_seq",   32'(out_seq),    32'd0);
    chk("rst_count",     32'(count),      32'd0);
    #1;
    nRST = 1'b1;
    tick();
    chk("post_rst_heard_rdy", 32'(heard__RDY), 32'd1);
    chk("post_rst_out_ena",   32'(out__ENA),   32'd0);

    // Single pass: no empty bypass, visible next cycle, gone the cycle after
    heard__ENA = 1'b1;
    heard_v    = 32'h0000_00AA;
    out__RDY   = 1'b1;
    settle();
    chk("sp_c1_out_ena", 32'(out__ENA), 32'd0);
    chk("sp_c1_out_v",   out_v,         32'd0);
    tick();
    heard__ENA = 1'b0;
    settle();
    chk("sp_c2_out_ena", 32'(out__ENA), 32'd1);
    chk("sp_c2_out_v",   out_v,         32'h0000_00AA);
    chk("sp_c2_out_seq", 32'(out_seq),  32'd0);
    chk("sp_c2_count",   32'(count),    32'd1);
    tick();
    chk("sp_c3_count",   32'(count),    32'd0);
    chk("sp_c3_out_ena", 32'(out__ENA), 32'd0);
    chk("sp_c3_out_seq", 32'(out_seq),  32'd0);

    // Fill to full, ignored fifth heard, then drain in order
    do_reset();
    fill4(32'h11, 32'h11);
    chk("full_count",     32'(count),      32'd4);
    chk("full_heard_rdy", 32'(heard__RDY), 32'd0);
    chk("full_out_ena",   32'(out__ENA),   32'd0);
    chk("full_hold_v",    out_v,           32'h11);
    heard__ENA = 1'b1;
    heard_v    = 32'h99;
    tick();
    heard__ENA = 1'b0;
    settle();
    chk("full_ignored_count", 32'(count), 32'd4);
    chk("full_hold_v2",       out_v,      32'h11);
    chk("full_hold_seq",      32'(out_seq), 32'd0);
    out__RDY = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("drain_ena", 32'(out__ENA), 32'd1);
      chk("drain_v",   out_v,         32'h11 * 32'(i + 1));
      chk("drain_seq", 32'(out_seq),  32'(i));
      tick();
    end
    chk("drain_empty", 32'(count), 32'd0);

    // Full with simultaneous dequeue: no full bypass
    do_reset();
    fill4(32'h1, 32'h1);
    out__RDY   = 1'b1;
    heard__ENA = 1'b1;
    heard_v    = 32'h5;
    settle();
    chk("fd_heard_rdy", 32'(heard__RDY), 32'd0);
    chk("fd_out_ena",   32'(out__ENA),   32'd1);
    tick();
    chk("fd_count_a",     32'(count),      32'd3);
    chk("fd_heard_rdy_a", 32'(heard__RDY), 32'd1);
    tick();
    heard__ENA = 1'b0;
    settle();
    chk("fd_count_b", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("fd_drain_v",   out_v,        32'(i + 3));
      chk("fd_drain_seq", 32'(out_seq), 32'(i + 2));
      tick();
    end
    chk("fd_empty", 32'(count), 32'd0);

    // Steady streaming for 20 cycles, pointers wrap five times
    do_reset();
    out__RDY   = 1'b1;
    heard__ENA = 1'b1;
    heard_v    = 32'h100;
    tick();
    for (int i = 1; i < 20; i++) begin
      heard_v = 32'h100 + 32'(i);
      settle();
      chk("st_count", 32'(count),   32'd1);
      chk("st_v",     out_v,        32'h100 + 32'(i - 1));
      chk("st_seq",   32'(out_seq), 32'(i - 1));
      tick();
    end
    heard__ENA = 1'b0;
    settle();
    chk("st_last_v",   out_v,        32'h113);
    chk("st_last_seq", 32'(out_seq), 32'd19);
    tick();
    chk("st_empty", 32'(count), 32'd0);

    // Asynchronous reset mid-operation
    do_reset();
    out__RDY   = 1'b0;
    heard__ENA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      heard_v = 32'h70 + 32'(i);
      tick();
    end
    heard__ENA = 1'b0;
    settle();
    chk("ar_count_pre", 32'(count), 32'd3);
    out__RDY = 1'b1;
    settle();
    chk("ar_ena_pre", 32'(out__ENA), 32'd1);
    nRST = 1'b0;
    settle();
    chk("ar_count", 32'(count),    32'd0);
    chk("ar_ena",   32'(out__ENA), 32'd0);
    chk("ar_v",     out_v,         32'd0);
    nRST = 1'b1;
    heard__ENA = 1'b1;
    heard_v    = 32'h55;
    tick();
    heard__ENA = 1'b0;
    settle();
    chk("ar_after_v",   out_v,         32'h55);
    chk("ar_after_seq", 32'(out_seq),  32'd0);
    chk("ar_after_ena", 32'(out__ENA), 32'd1);
    tick();

    // Sequence counter wrap across 65537 accepted entries
    do_reset();
    out__RDY   = 1'b1;
    heard__ENA = 1'b1;
    for (int k = 1; k <= 65537; k++) begin
      heard_v = 32'(k);
      tick();
      if (k == 1 || k == 65536 || k == 65537) begin
        chk("wrap_v",   out_v,        32'(k));
        chk("wrap_seq", 32'(out_seq), (k == 65537) ? 32'h0 : 32'(k - 1));
      end
    end
    heard__ENA = 1'b0;
    tick();
    chk("wrap_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
